rc4_core_word_ctrl: RTL and testbench

Sequencer for the RC4 decryption word path. It fetches a 32-bit ciphertext word and XORs each of its four bytes with one keystream byte. It drives the byte-packing register (enable/location/data), then issues a 32-bit write of the packed plaintext word. It runs a programmed number of consecutive words per start and sits between the RC4 keystream generator, the memory read/write ports and the decrypted-data packer.

---
 rtl/rc4_core_word_ctrl_if.sv | 38 +++
 rtl/rc4_core_word_ctrl.sv | 96 +++++++++
 tb/tb_rc4_core_word_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_core_word_ctrl_if.sv
// Bus bundle for the RC4 word-path sequencer: memory read/write ports,
// keystream handshake and byte-packer strobes.
interface rc4_core_word_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] num_words_i;
  logic              rd_req_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_ack_i;
  logic [31:0]       rd_data_i;
  logic              ks_valid_i;
  logic [7:0]        ks_byte_i;
  logic              ks_ready_o;
  logic              enable_write_o;
  logic [1:0]        writeLoc_o;
  logic [7:0]        data_o;
  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              wr_ack_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, base_addr_i, num_words_i, rd_ack_i, rd_data_i,
           ks_valid_i, ks_byte_i, wr_ack_i,
    output rd_req_o, rd_addr_o, ks_ready_o, enable_write_o, writeLoc_o,
           data_o, wr_req_o, wr_addr_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, num_words_i, rd_ack_i, rd_data_i,
           ks_valid_i, ks_byte_i, wr_ack_i,
    input  rd_req_o, rd_addr_o, ks_ready_o, enable_write_o, writeLoc_o,
           data_o, wr_req_o, wr_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/rc4_core_word_ctrl.sv
// RC4 decryption word sequencer: read ciphertext word, XOR four bytes with
// keystream into the packer, write the plaintext word back in place.
module rc4_core_word_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic rst,
  rc4_core_word_ctrl_if.master bus
);
  // state   | meaning
  // S_IDLE  | waiting for start_i
  // S_READ  | ciphertext read request outstanding
  // S_XOR   | consuming keystream, one packer strobe per valid byte
  // S_WRITE | plaintext write request outstanding
  // S_DONE  | one-cycle end-of-run pulse
  typedef enum logic [2:0] {S_IDLE, S_READ, S_XOR, S_WRITE, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       cipher_q;
  logic [7:0]        lane;
  logic              strobe;

  assign addr_d      = addr_q + 1'b1;
  assign remaining_d = remaining_q - 1'b1;
  assign idx_d       = idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= 2'd0;
      cipher_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            addr_q      <= bus.base_addr_i;
            remaining_q <= bus.num_words_i;
            idx_q       <= 2'd0;
            state_q     <= (bus.num_words_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (bus.rd_ack_i) begin
            cipher_q <= bus.rd_data_i;
            idx_q    <= 2'd0;
            state_q  <= S_XOR;
          end
        end
        S_XOR: begin
          if (bus.ks_valid_i) begin
            idx_q <= idx_d;
            if (idx_q == 2'd3) state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.wr_ack_i) begin
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            state_q     <= (remaining_d == '0) ? S_DONE : S_READ;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Lane 0 is the most significant byte of the ciphertext word.
  always_comb begin
    lane = 8'h00;
    case (idx_q)
      2'd0: lane = cipher_q[31:24];
      2'd1: lane = cipher_q[23:16];
      2'd2: lane = cipher_q[15:8];
      2'd3: lane = cipher_q[7:0];
      default: lane = 8'h00;
    endcase
  end

  assign strobe             = (state_q == S_XOR) && bus.ks_valid_i;
  assign bus.ks_ready_o     = (state_q == S_XOR);
  assign bus.enable_write_o = strobe;
  assign bus.writeLoc_o     = strobe ? idx_q : 2'd0;
  assign bus.data_o         = strobe ? (lane ^ bus.ks_byte_i) : 8'h00;
  assign bus.rd_req_o       = (state_q == S_READ);
  assign bus.rd_addr_o      = (state_q == S_READ) ? addr_q : '0;
  assign bus.wr_req_o       = (state_q == S_WRITE);
  assign bus.wr_addr_o      = (state_q == S_WRITE) ? addr_q : '0;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.done_o         = (state_q == S_DONE);
endmodule

// File: tb/tb_rc4_core_word_ctrl.sv
// Directed bench for rc4_core_word_ctrl with hand-computed strobe data,
// addresses and cycle positions.
module tb_rc4_core_word_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] ks_tab [16];
  int         ks_k = 0;
  logic       ks_pend = 1'b0;

  rc4_core_word_ctrl_if #(.ADDR_W(16)) bus ();

  rc4_core_word_ctrl #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed view: rd_req rd_addr ks_ready en loc data wr_req wr_addr busy done
  function automatic logic [47:0] ev(input logic rq, input logic [15:0] ra,
      input logic kr, input logic en, input logic [1:0] loc, input logic [7:0] d,
      input logic wq, input logic [15:0] wa, input logic b, input logic dn);
    return {rq, ra, kr, en, loc, d, wq, wa, b, dn};
  endfunction

  // Addresses and lane are only meaningful alongside their qualifier.
  function automatic logic [47:0] msk(input logic [47:0] e);
    logic [47:0] m;
    m = '1;
    if (!e[47]) m[46:31] = '0;
    if (!e[29]) m[28:27] = '0;
    if (!e[18]) m[17:2]  = '0;
    return m;
  endfunction

  function automatic logic [47:0] obs();
    return {bus.rd_req_o, bus.rd_addr_o, bus.ks_ready_o, bus.enable_write_o,
            bus.writeLoc_o, bus.data_o, bus.wr_req_o, bus.wr_addr_o,
            bus.busy_o, bus.done_o};
  endfunction

  // One cycle of environment: drive inputs after the falling edge, settle,
  // and advance the keystream source when a byte was consumed.
  task automatic step(input logic st, input logic ra, input logic wa, input logic kv);
    @(negedge clk);
    if (ks_pend) ks_k++;
    bus.start_i    = st;
    bus.rd_ack_i   = ra;
    bus.wr_ack_i   = wa;
    bus.ks_valid_i = kv;
    bus.ks_byte_i  = kv ? ks_tab[ks_k % 16] : 8'hFF;
    #1;
    ks_pend = bus.ks_ready_o && kv;
  endtask

  task automatic launch(input logic [15:0] base, input logic [15:0] n, input logic [31:0] rdat);
    ks_k = 0;
    ks_pend = 1'b0;
    bus.base_addr_i = base;
    bus.num_words_i = n;
    bus.rd_data_i   = rdat;
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [47:0] o;
    @(negedge clk);
    #1;
    o = obs();
    total++;
    if (o !== 48'h0) begin bad++; $display("FAIL reset_hold got=%h exp=0", o); end
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    o = obs();
    total++;
    if (o !== 48'h0) begin bad++; $display("FAIL reset_idle got=%h exp=0", o); end
  endtask

  task automatic test_single_word();
    logic [47:0] e, o, m;
    logic [7:0] xd [4];
    xd[0] = 8'hCF; xd[1] = 8'h8F; xd[2] = 8'h8D; xd[3] = 8'hAB;
    ks_tab[0] = 8'h11; ks_tab[1] = 8'h22; ks_tab[2] = 8'h33; ks_tab[3] = 8'h44;
    launch(16'h0010, 16'd1, 32'hDEADBEEF);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      e = 48'h0;
      if (c == 1) e = ev(1, 16'h0010, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 5) e = ev(0, 16'h0, 1, 1, 2'(c-2), xd[c-2], 0, 16'h0, 1, 0);
      else if (c == 6) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, 16'h0010, 1, 0);
      else if (c == 7) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL single c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
  endtask

  task automatic test_ks_stall();
    logic [47:0] e, o, m;
    logic [7:0] xd [4];
    logic kv;
    int s;
    xd[0] = 8'h11; xd[1] = 8'h03; xd[2] = 8'h75; xd[3] = 8'h27;
    ks_tab[0] = 8'h10; ks_tab[1] = 8'h20; ks_tab[2] = 8'h30; ks_tab[3] = 8'h40;
    launch(16'h0020, 16'd1, 32'h01234567);
    s = 0;
    for (int c = 1; c <= 11; c++) begin
      kv = !(c >= 4 && c <= 6);
      step(1'b0, 1'b1, 1'b1, kv);
      e = 48'h0;
      if (c == 1) e = ev(1, 16'h0020, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 8 && !kv) e = ev(0, 16'h0, 1, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 8) begin e = ev(0, 16'h0, 1, 1, 2'(s), xd[s], 0, 16'h0, 1, 0); s++; end
      else if (c == 9) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, 16'h0020, 1, 0);
      else if (c == 10) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL ks_stall c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
  endtask

  task automatic test_ack_delay();
    logic [47:0] e, o, m;
    logic [7:0] xd [4];
    int writes;
    xd[0] = 8'hA4; xd[1] = 8'hA7; xd[2] = 8'hA6; xd[3] = 8'hA1;
    ks_tab[0] = 8'h01; ks_tab[1] = 8'h02; ks_tab[2] = 8'h03; ks_tab[3] = 8'h04;
    launch(16'h0030, 16'd1, 32'hA5A5A5A5);
    writes = 0;
    for (int c = 1; c <= 17; c++) begin
      step(1'b0, c == 6, c == 15, 1'b1);
      if (bus.wr_req_o && bus.wr_ack_i) writes++;
      e = 48'h0;
      if (c <= 6) e = ev(1, 16'h0030, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 10) e = ev(0, 16'h0, 1, 1, 2'(c-7), xd[c-7], 0, 16'h0, 1, 0);
      else if (c <= 15) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, 16'h0030, 1, 0);
      else if (c == 16) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL ack_delay c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
    total++;
    if (writes !== 1) begin bad++; $display("FAIL ack_delay_writes got=%0d exp=1", writes); end
  endtask

  task automatic test_multi_wrap();
    logic [47:0] e, o, m;
    logic [15:0] wa [3];
    int w, p, strobes, dones;
    wa[0] = 16'hFFFE; wa[1] = 16'hFFFF; wa[2] = 16'h0000;
    for (int i = 0; i < 16; i++) ks_tab[i] = 8'(i + 1);
    launch(16'hFFFE, 16'd3, 32'h00000000);
    strobes = 0; dones = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (bus.enable_write_o) strobes++;
      if (bus.done_o) dones++;
      w = (c - 1) / 6; p = (c - 1) % 6;
      e = 48'h0;
      if (c <= 18) begin
        if (p == 0) e = ev(1, wa[w], 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
        else if (p <= 4) e = ev(0, 16'h0, 1, 1, 2'(p-1), 8'(4*w + p), 0, 16'h0, 1, 0);
        else e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, wa[w], 1, 0);
      end else if (c == 19) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL multi_wrap c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
    total++;
    if (strobes !== 12) begin bad++; $display("FAIL multi_strobes got=%0d exp=12", strobes); end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL multi_dones got=%0d exp=1", dones); end
  endtask

  task automatic test_zero_words();
    logic [47:0] e, o;
    launch(16'h1234, 16'd0, 32'hFFFFFFFF);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      e = (c == 1) ? ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1) : 48'h0;
      o = obs();
      total++;
      if (o !== e) begin bad++; $display("FAIL zero_words c=%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  task automatic test_start_busy();
    logic [47:0] e, o, m;
    logic st;
    for (int i = 0; i < 4; i++) ks_tab[i] = 8'hAA + 8'(17 * i);
    launch(16'h0050, 16'd1, 32'h00000000);
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin bus.base_addr_i = 16'h9999; bus.num_words_i = 16'd5; end
      st = (c == 3) || (c == 5) || (c == 6);
      step(st, 1'b1, 1'b1, 1'b1);
      e = 48'h0;
      if (c == 1) e = ev(1, 16'h0050, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 5) e = ev(0, 16'h0, 1, 1, 2'(c-2), 8'hAA + 8'(17*(c-2)), 0, 16'h0, 1, 0);
      else if (c == 6) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, 16'h0050, 1, 0);
      else if (c == 7) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL start_busy c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
  endtask

  task automatic test_reset_mid_xor();
    logic [47:0] e, o, m;
    logic [7:0] xd [4];
    ks_tab[0] = 8'h01; ks_tab[1] = 8'h02; ks_tab[2] = 8'h03; ks_tab[3] = 8'h04;
    launch(16'h0040, 16'd1, 32'h11111111);
    for (int c = 1; c <= 3; c++) step(1'b0, 1'b1, 1'b1, 1'b1);
    o = obs();
    total++;
    if (o[29] !== 1'b1 || o[26:19] !== 8'h13) begin bad++; $display("FAIL pre_reset_strobe got=%h exp_data=13", o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    o = obs();
    total++;
    if (o !== 48'h0) begin bad++; $display("FAIL reset_mid got=%h exp=0", o); end
    @(negedge clk);
    rst = 1'b0;
    ks_pend = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      o = obs();
      total++;
      if (o !== 48'h0) begin bad++; $display("FAIL reset_after c=%0d got=%h exp=0", c, o); end
    end
    xd[0] = 8'hF0; xd[1] = 8'hE1; xd[2] = 8'hD2; xd[3] = 8'hC3;
    ks_tab[0] = 8'h0F; ks_tab[1] = 8'h1E; ks_tab[2] = 8'h2D; ks_tab[3] = 8'h3C;
    launch(16'h0041, 16'd1, 32'hFFFFFFFF);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      e = 48'h0;
      if (c == 1) e = ev(1, 16'h0041, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 0);
      else if (c <= 5) e = ev(0, 16'h0, 1, 1, 2'(c-2), xd[c-2], 0, 16'h0, 1, 0);
      else if (c == 6) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 1, 16'h0041, 1, 0);
      else if (c == 7) e = ev(0, 16'h0, 0, 0, 2'd0, 8'h00, 0, 16'h0, 1, 1);
      o = obs(); m = msk(e);
      total++;
      if ((o & m) !== (e & m)) begin bad++; $display("FAIL rerun c=%0d got=%h exp=%h", c, o & m, e & m); end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.base_addr_i = 16'h0;
    bus.num_words_i = 16'h0;
    bus.rd_ack_i = 1'b0;
    bus.rd_data_i = 32'h0;
    bus.ks_valid_i = 1'b0;
    bus.ks_byte_i = 8'h0;
    bus.wr_ack_i = 1'b0;
    for (int i = 0; i < 16; i++) ks_tab[i] = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_word();
    test_ks_stall();
    test_ack_delay();
    test_multi_wrap();
    test_zero_words();
    test_start_busy();
    test_reset_mid_xor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
